// File: rtl/dcache_controller_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_package: the shared RV32I core types, plus the data cache FSM state.
//   cpu_req_type   : addr, data, rw (1 = write), valid. Used core->cache and
//                    cache->memory.
//   cpu_res_type   : data, ready. Used cache->core and memory->cache.
//   dcache_state_t : controller FSM states.
// -----------------------------------------------------------------------------
package rv32i_package;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_res_type;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        COMPARE       = 3'd1,
        ALLOCATE      = 3'd2,
        WRITE_THROUGH = 3'd3,
        RESPOND       = 3'd4
    } dcache_state_t;

endpackage

// File: rtl/dcache_controller_array.sv
// -----------------------------------------------------------------------------
// dcache_array: line storage for the direct-mapped data cache.
//   clk, rst       : clock, async active-high reset (clears valid bits only)
//   rd_idx_i       : combinational read index
//   rd_valid_o/rd_tag_o/rd_data_o : contents of line rd_idx_i
//   we_i, wr_idx_i, wr_tag_i, wr_data_i : synchronous write; sets valid
// -----------------------------------------------------------------------------
module dcache_array #(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: a line is only looked at when valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_mem[rd_idx_i];
    assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller: direct-mapped, write-through, no-write-allocate data cache
// with one 32-bit word per line.
//   clk, rst : clock, async active-high reset
//   cpu_req  : core request (addr, data, rw, valid)
//   cpu_res  : core response (data, ready); ready is a one-cycle pulse
//   mem_req  : backing-memory request, held stable while valid
//   mem_res  : backing-memory response; ready honoured in ALLOCATE/WRITE_THROUGH
//   state_o  : current FSM state, for observation
// Handshake: a request is taken when valid is seen in IDLE; the core holds it
// until the ready pulse. Memory completes a transfer in any cycle it raises
// ready while a cache request is outstanding, including the first one.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module dcache_controller
    import rv32i_package::*;
#(
    parameter int LINES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  cpu_req_type   cpu_req,
    output cpu_res_type   cpu_res,
    output cpu_req_type   mem_req,
    input  cpu_res_type   mem_res,
    output dcache_state_t state_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } line_t;

    dcache_state_t state_q, state_d;
    logic [29:0]   word_addr_q, word_addr_d;   // byte offset dropped at accept
    logic [31:0]   wdata_q, wdata_d;
    logic          rw_q, rw_d;
    cpu_res_type   cpu_res_q, cpu_res_d;
    cpu_req_type   mem_req_q, mem_req_d;

    line_t            rd_line;
    logic             hit;
    logic             arr_we;
    logic [31:0]      arr_wdata;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    // Byte offset within the word has no meaning for this cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_req.addr[1:0];

    assign idx = word_addr_q[IDX_W-1:0];
    assign tag = word_addr_q[29 -: TAG_W];

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (idx),
        .rd_valid_o (rd_line.valid),
        .rd_tag_o   (rd_line.tag),
        .rd_data_o  (rd_line.data),
        .we_i       (arr_we),
        .wr_idx_i   (idx),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_wdata)
    );

    assign hit = rd_line.valid && (rd_line.tag == tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            cpu_res_q   <= '0;
            mem_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            cpu_res_q   <= cpu_res_d;
            mem_req_q   <= mem_req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        cpu_res_d   = '0;          // ready and data only live in RESPOND
        mem_req_d   = mem_req_q;
        arr_we      = 1'b0;
        arr_wdata   = wdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req.valid) begin
                    word_addr_d = cpu_req.addr[31:2];
                    wdata_d     = cpu_req.data;
                    rw_d        = cpu_req.rw;
                    state_d     = COMPARE;
                end
            end
            COMPARE: begin
                if (!rw_q) begin
                    if (hit) begin
                        cpu_res_d.data  = rd_line.data;
                        cpu_res_d.ready = 1'b1;
                        state_d         = RESPOND;
                    end else begin
                        mem_req_d.addr  = {word_addr_q, 2'b00};
                        mem_req_d.data  = '0;
                        mem_req_d.rw    = 1'b0;
                        mem_req_d.valid = 1'b1;
                        state_d         = ALLOCATE;
                    end
                end else begin
                    // Write hit refreshes the word; tag and valid rewrite to
                    // the values they already hold. Write miss leaves the line.
                    arr_we          = hit;
                    arr_wdata       = wdata_q;
                    mem_req_d.addr  = {word_addr_q, 2'b00};
                    mem_req_d.data  = wdata_q;
                    mem_req_d.rw    = 1'b1;
                    mem_req_d.valid = 1'b1;
                    state_d         = WRITE_THROUGH;
                end
            end
            ALLOCATE: begin
                if (mem_res.ready) begin
                    arr_we          = 1'b1;
                    arr_wdata       = mem_res.data;
                    cpu_res_d.data  = mem_res.data;
                    cpu_res_d.ready = 1'b1;
                    mem_req_d       = '0;
                    state_d         = RESPOND;
                end
            end
            WRITE_THROUGH: begin
                if (mem_res.ready) begin
                    cpu_res_d.ready = 1'b1;
                    mem_req_d       = '0;
                    state_d         = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_res = cpu_res_q;
    assign mem_req = mem_req_q;
    assign state_o = state_q;

endmodule
